// File: rtl/pass_ctrl.sv
// pass_ctrl: keypad-side password sequencer. Buffers BCD digits, checks them
// against the stored password, emits one right/error pulse per attempt,
// enforces a timed lockout after repeated failures and handles password change.
module pass_ctrl #(
  parameter int                  DIGITS       = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_PASS = 16'h1234,
  parameter int                  MAX_FAIL     = 3,
  parameter int                  LOCKOUT_CYC  = 50_000_000,
  parameter int                  TIMEOUT_CYC  = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       right,
  output logic       error,
  output logic       chg_done,
  output logic       locked_out,
  output logic [3:0] entry_cnt,
  output logic [2:0] state
);
  localparam int BW = 4*DIGITS;
  localparam int LW = $clog2(LOCKOUT_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [3:0]    KEY_ENTER = 4'hA;
  localparam logic [3:0]    KEY_CLEAR = 4'hB;
  localparam logic [3:0]    KEY_CHG   = 4'hC;
  localparam logic [3:0]    FULL_CNT  = 4'(DIGITS);
  localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_NEW   = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  state_t        r_state,    w_state;
  logic [BW-1:0] r_buf,      w_buf;
  logic [BW-1:0] r_pass,     w_pass;
  logic [BW-1:0] w_shift;
  logic [3:0]    r_cnt,      w_cnt;
  logic [2:0]    r_fail,     w_fail;
  logic          r_chg_req,  w_chg_req;
  logic [LW-1:0] r_lock_cnt, w_lock_cnt;
  logic [TW-1:0] r_to_cnt,   w_to_cnt;
  logic          r_right,    w_right;
  logic          r_error,    w_error;
  logic          r_chg_done, w_chg_done;
  logic          r_locked;

  logic w_digit, w_enter, w_clear, w_chg, w_full, w_match, w_expire, w_in_entry;
  logic [2:0] w_fail_inc;

  assign w_digit    = key_valid && (key_code <= 4'd9);
  assign w_enter    = key_valid && (key_code == KEY_ENTER);
  assign w_clear    = key_valid && (key_code == KEY_CLEAR);
  assign w_chg      = key_valid && (key_code == KEY_CHG);
  assign w_full     = (r_cnt == FULL_CNT);
  assign w_match    = w_full && (r_buf == r_pass);
  assign w_fail_inc = r_fail + 3'd1;
  assign w_in_entry = (r_state == S_ENTRY) || (r_state == S_NEW);
  // a key in the expiry cycle wins over the timeout
  assign w_expire   = !key_valid && (r_to_cnt == TO_LAST);

  // entry buffer with the new digit shifted into the low nibble
  always_comb begin
    w_shift      = r_buf << 4;
    w_shift[3:0] = key_code;
  end

  // next-state and datapath decode
  always_comb begin
    w_state    = r_state;
    w_buf      = r_buf;
    w_cnt      = r_cnt;
    w_pass     = r_pass;
    w_fail     = r_fail;
    w_chg_req  = r_chg_req;
    w_lock_cnt = r_lock_cnt;
    w_right    = 1'b0;
    w_error    = 1'b0;
    w_chg_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_digit) begin
          w_buf      = '0;
          w_buf[3:0] = key_code;
          w_cnt      = 4'd1;
          w_state    = S_ENTRY;
        end else if (w_chg) begin
          w_chg_req = 1'b1;
          w_buf     = '0;
          w_cnt     = 4'd0;
          w_state   = S_ENTRY;
        end
      end
      S_ENTRY, S_NEW: begin
        if (w_digit) begin
          // digits past a full buffer are dropped
          if (!w_full) begin
            w_buf = w_shift;
            w_cnt = r_cnt + 4'd1;
          end
        end else if (w_enter) begin
          if (r_state == S_ENTRY) begin
            w_state = S_CHECK;
          end else begin
            if (w_full) begin
              w_pass     = r_buf;
              w_chg_done = 1'b1;
            end else begin
              w_error = 1'b1;
            end
            w_buf   = '0;
            w_cnt   = 4'd0;
            w_state = S_IDLE;
          end
        end else if (w_clear || w_expire) begin
          w_buf     = '0;
          w_cnt     = 4'd0;
          w_chg_req = 1'b0;
          w_state   = S_IDLE;
        end
      end
      S_CHECK: begin
        w_buf     = '0;
        w_cnt     = 4'd0;
        w_chg_req = 1'b0;
        if (w_match) begin
          w_fail  = 3'd0;
          w_right = !r_chg_req;
          w_state = r_chg_req ? S_NEW : S_IDLE;
        end else begin
          w_error = 1'b1;
          if (w_fail_inc == FAIL_MAX) begin
            w_fail     = 3'd0;
            w_lock_cnt = LOCK_LOAD;
            w_state    = S_LOCK;
          end else begin
            w_fail  = w_fail_inc;
            w_state = S_IDLE;
          end
        end
      end
      S_LOCK: begin
        if (r_lock_cnt == '0) w_state    = S_IDLE;
        else                  w_lock_cnt = r_lock_cnt - LW'(1);
      end
      default: begin
        w_buf   = '0;
        w_cnt   = 4'd0;
        w_state = S_IDLE;
      end
    endcase
  end

  // inactivity counter restarts on any key and on every state change
  assign w_to_cnt = (key_valid || (w_state != r_state) || !w_in_entry) ? '0
                                                                       : r_to_cnt + TW'(1);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state;
  end

  // datapath, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf      <= '0;
      r_cnt      <= 4'd0;
      r_pass     <= DEFAULT_PASS;
      r_fail     <= 3'd0;
      r_chg_req  <= 1'b0;
      r_lock_cnt <= '0;
      r_to_cnt   <= '0;
      r_right    <= 1'b0;
      r_error    <= 1'b0;
      r_chg_done <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_buf      <= w_buf;
      r_cnt      <= w_cnt;
      r_pass     <= w_pass;
      r_fail     <= w_fail;
      r_chg_req  <= w_chg_req;
      r_lock_cnt <= w_lock_cnt;
      r_to_cnt   <= w_to_cnt;
      r_right    <= w_right;
      r_error    <= w_error;
      r_chg_done <= w_chg_done;
      r_locked   <= (w_state == S_LOCK);
    end
  end

  assign right      = r_right;
  assign error      = r_error;
  assign chg_done   = r_chg_done;
  assign locked_out = r_locked;
  assign entry_cnt  = r_cnt;
  assign state      = r_state;

endmodule
